// File: rtl/demux_stream_12_pkg.sv
// Shared defaults and width helpers for the stream demultiplexer slice.
// Imported by the FIFO and the steering top.
package demux_stream_12_pkg;

  localparam int DS_N     = 32;
  localparam int DS_DEPTH = 2;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level counter; full/empty derive from the level.
// Full refuses pushes even when a pop happens the same cycle (no bypass).
module sync_fifo
  import demux_stream_12_pkg::*;
#(
  parameter int N     = DS_N,
  parameter int DEPTH = DS_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [N-1:0]           push_data,
  output logic                   full,
  input  logic                   pop,
  output logic [N-1:0]           pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W = lvl_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [N-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (lvl_q == LVL_W'(DEPTH));
  assign empty    = (lvl_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_q];
  assign level    = lvl_q;

  // Next-state pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // Pointer and level registers; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/demux_stream_12.sv
// 1-to-2 stream steering: in_sel picks FIFO A or B.
// Each output has its own FIFO so one stalled consumer never blocks the other.
module demux_stream_12
  import demux_stream_12_pkg::*;
#(
  parameter int N     = DS_N,
  parameter int DEPTH = DS_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sel,
  input  logic [N-1:0]           in_data,
  output logic                   in_ready,
  output logic                   a_valid,
  output logic [N-1:0]           a_data,
  input  logic                   a_ready,
  output logic                   b_valid,
  output logic [N-1:0]           b_data,
  input  logic                   b_ready,
  output logic [$clog2(DEPTH):0] a_level,
  output logic [$clog2(DEPTH):0] b_level
);

  localparam int LVL_W = lvl_w(DEPTH);

  logic             a_full, b_full;
  logic             a_empty, b_empty;
  logic             push_a, push_b;
  logic             accept;
  logic [LVL_W-1:0] a_lvl, b_lvl;

  // Readiness looks only at the selected FIFO, never at consumer ready.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) in_ready = in_sel ? ~b_full : ~a_full;
  end

  assign accept = in_valid & in_ready;
  assign push_a = accept & ~in_sel;
  assign push_b = accept & in_sel;

  assign a_valid = ~a_empty;
  assign b_valid = ~b_empty;
  assign a_level = a_lvl;
  assign b_level = b_lvl;

  sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .full      (a_full),
    .pop       (a_ready),
    .pop_data  (a_data),
    .empty     (a_empty),
    .level     (a_lvl)
  );

  sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .full      (b_full),
    .pop       (b_ready),
    .pop_data  (b_data),
    .empty     (b_empty),
    .level     (b_lvl)
  );

endmodule

// File: tb/tb_demux_stream_12.sv
// Bench for demux_stream_12: vector table plus per-output scoreboard queues.
// Inputs change on negedge; outputs sampled 1ns later, model steps on posedge.
module tb_demux_stream_12;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_sel;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         a_valid;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [N-1:0] b_data;
  logic         b_ready;
  logic [1:0]   a_level;
  logic [1:0]   b_level;

  int n_chk  = 0;
  int n_fail = 0;
  int a_pops = 0;
  int b_pops = 0;

  logic [N-1:0] qa [$];
  logic [N-1:0] qb [$];

  always #5 clk = ~clk;

  demux_stream_12 #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .a_level  (a_level),
    .b_level  (b_level)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        ar;
    logic        br;
    logic        e_rdy;
    int          e_al;
    int          e_bl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic model_rdy();
    if (rst) return 1'b0;
    return in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
  endfunction

  // Drive one cycle's inputs and compare outputs against the scoreboard.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [31:0] d, input logic ar,
                       input logic br);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
    chk("in_ready", 32'(in_ready), 32'(model_rdy()));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    chk("a_level", 32'(a_level), 32'(qa.size()));
    chk("b_level", 32'(b_level), 32'(qb.size()));
    if (qa.size() != 0) chk("a_data", a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", b_data, qb[0]);
  endtask

  // Advance the clock and the scoreboard in step with it.
  task automatic tick();
    logic acc;
    acc = in_valid && model_rdy();
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_ready && qa.size() != 0) begin
        void'(qa.pop_front());
        a_pops++;
      end
      if (b_ready && qb.size() != 0) begin
        void'(qb.pop_front());
        b_pops++;
      end
      if (acc) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
  endtask

  vec_t vecs [15];

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    @(posedge clk);

    //          r     v     s     d      ar    br    rdy   al bl
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h01, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h02, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h03, 1'b0, 1'b0, 1'b0, 2, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 2, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h03, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h03, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 2, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d,
            vecs[i].ar, vecs[i].br);
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_al", i), 32'(a_level), 32'(vecs[i].e_al));
      chk($sformatf("v%0d_bl", i), 32'(b_level), 32'(vecs[i].e_bl));
      tick();
    end

    // Throughput: alternating destinations with both consumers ready.
    a_pops = 0;
    b_pops = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'(i % 2), 32'h100 + 32'(i), 1'b1, 1'b1);
      chk("thru_rdy", 32'(in_ready), 32'd1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
    end
    chk("thru_a_cnt", 32'(a_pops), 32'd8);
    chk("thru_b_cnt", 32'(b_pops), 32'd8);

    // Reset with A full; stale entries must never reappear.
    drive(1'b0, 1'b1, 1'b0, 32'hD1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'hD2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hBB, 1'b0, 1'b0);
    chk("rst_full_al", 32'(a_level), 32'd2);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'hAA, 1'b0, 1'b0);
    chk("post_rst_av", 32'(a_valid), 32'd0);
    chk("post_rst_al", 32'(a_level), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("aa_data", a_data, 32'hAA);
    chk("aa_al", 32'(a_level), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("aa_gone_av", 32'(a_valid), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("stale_av", 32'(a_valid), 32'd0);
    chk("stale_bv", 32'(b_valid), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
